// File: rtl/ddr_chan_arbiter_if.sv
// rtl/ddr_chan_arbiter_if.sv - requester and DDR engine signal bundle for ddr_chan_arbiter
interface ddr_chan_arbiter_if #(
  parameter int REQ_NUM = 2,
  parameter int ADDR_W  = 32,
  parameter int BURST_W = 16
);
  localparam int PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  logic [REQ_NUM-1:0]         req_start;
  logic [REQ_NUM*ADDR_W-1:0]  req_st_addr;
  logic [REQ_NUM*BURST_W-1:0] req_burst;
  logic [REQ_NUM*ADDR_W-1:0]  req_step;
  logic [REQ_NUM*BURST_W-1:0] req_burst_num;
  logic [REQ_NUM-1:0]         req_done;
  logic                       wr_start;
  logic [ADDR_W-1:0]          wr_st_addr;
  logic [BURST_W-1:0]         wr_burst;
  logic [ADDR_W-1:0]          wr_step;
  logic [BURST_W-1:0]         wr_burst_num;
  logic                       wr_done;
  logic                       busy;
  logic [PTR_W-1:0]           owner;
  logic [REQ_NUM-1:0]         err_ovf;
  logic                       err_clr;

  modport slave (
    input  req_start, req_st_addr, req_burst, req_step, req_burst_num, wr_done, err_clr,
    output req_done, wr_start, wr_st_addr, wr_burst, wr_step, wr_burst_num, busy, owner, err_ovf
  );

  modport master (
    output req_start, req_st_addr, req_burst, req_step, req_burst_num, wr_done, err_clr,
    input  req_done, wr_start, wr_st_addr, wr_burst, wr_step, wr_burst_num, busy, owner, err_ovf
  );
endinterface

// File: rtl/ddr_chan_arbiter.sv
// rtl/ddr_chan_arbiter.sv - round-robin sharing of one DDR transfer engine between requesters
// Start pulses latch a descriptor per slot; the engine is granted to one slot at a time.
module ddr_chan_arbiter #(
  parameter int REQ_NUM = 2,
  parameter int ADDR_W  = 32,
  parameter int BURST_W = 16
) (
  input logic              clk,
  input logic              rst,
  ddr_chan_arbiter_if.slave bus
);
  localparam int PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t state, state_nxt;

  logic [REQ_NUM-1:0] pend, slot_busy, accept, ovf;
  logic [REQ_NUM-1:0] grant_mask, done_mask, req_done_q, err_ovf_q;
  logic [PTR_W-1:0]   rr_ptr, owner_q, sel, rr_nxt;
  logic               sel_vld, grant, done_ev;

  logic [ADDR_W-1:0]  h_addr [REQ_NUM];
  logic [BURST_W-1:0] h_burst [REQ_NUM];
  logic [ADDR_W-1:0]  h_step [REQ_NUM];
  logic [BURST_W-1:0] h_num [REQ_NUM];

  logic [ADDR_W-1:0]  wr_addr_q, wr_step_q;
  logic [BURST_W-1:0] wr_burst_q, wr_num_q;

  // A slot stays busy from capture until its transfer returns to IDLE.
  always_comb begin
    for (int i = 0; i < REQ_NUM; i++) begin
      slot_busy[i] = pend[i] | ((state != IDLE) && (owner_q == PTR_W'(i)));
      accept[i]    = bus.req_start[i] & ~slot_busy[i];
      ovf[i]       = bus.req_start[i] & slot_busy[i];
    end
  end

  always_comb begin
    int idx;
    logic [PTR_W-1:0] idx_t;
    sel     = '0;
    sel_vld = 1'b0;
    idx     = 0;
    idx_t   = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= REQ_NUM) idx = idx - REQ_NUM;
      idx_t = idx[PTR_W-1:0];
      if (!sel_vld && pend[idx_t]) begin
        sel_vld = 1'b1;
        sel     = idx_t;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    done_ev   = 1'b0;
    case (state)
      IDLE: begin
        if (sel_vld) begin
          grant     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (bus.wr_done) begin
          done_ev   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant_mask = '0;
    done_mask  = '0;
    if (grant) grant_mask[sel] = 1'b1;
    done_mask[owner_q] = 1'b1;
    rr_nxt = (owner_q == PTR_W'(REQ_NUM - 1)) ? '0 : owner_q + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend       <= '0;
      rr_ptr     <= '0;
      owner_q    <= '0;
      req_done_q <= '0;
      err_ovf_q  <= '0;
      wr_addr_q  <= '0;
      wr_burst_q <= '0;
      wr_step_q  <= '0;
      wr_num_q   <= '0;
      for (int i = 0; i < REQ_NUM; i++) begin
        h_addr[i]  <= '0;
        h_burst[i] <= '0;
        h_step[i]  <= '0;
        h_num[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < REQ_NUM; i++) begin
        if (accept[i]) begin
          h_addr[i]  <= bus.req_st_addr[i*ADDR_W +: ADDR_W];
          h_burst[i] <= bus.req_burst[i*BURST_W +: BURST_W];
          h_step[i]  <= bus.req_step[i*ADDR_W +: ADDR_W];
          h_num[i]   <= bus.req_burst_num[i*BURST_W +: BURST_W];
        end
      end
      // accept and grant never hit the same slot: accept needs pend=0, grant needs pend=1
      pend      <= (pend | accept) & ~grant_mask;
      err_ovf_q <= (bus.err_clr ? '0 : err_ovf_q) | ovf;
      if (grant) begin
        owner_q    <= sel;
        wr_addr_q  <= h_addr[sel];
        wr_burst_q <= h_burst[sel];
        wr_step_q  <= h_step[sel];
        wr_num_q   <= h_num[sel];
      end
      if (done_ev) begin
        rr_ptr     <= rr_nxt;
        req_done_q <= done_mask;
      end else begin
        req_done_q <= '0;
      end
    end
  end

  assign bus.req_done     = req_done_q;
  assign bus.wr_start     = (state == ISSUE);
  assign bus.wr_st_addr   = wr_addr_q;
  assign bus.wr_burst     = wr_burst_q;
  assign bus.wr_step      = wr_step_q;
  assign bus.wr_burst_num = wr_num_q;
  assign bus.busy         = (state != IDLE);
  assign bus.owner        = owner_q;
  assign bus.err_ovf      = err_ovf_q;
endmodule

// File: tb/tb_ddr_chan_arbiter.sv
// tb/tb_ddr_chan_arbiter.sv - directed self-checking bench for ddr_chan_arbiter
module tb_ddr_chan_arbiter;
  localparam int REQ_NUM = 2;
  localparam int ADDR_W  = 32;
  localparam int BURST_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  ddr_chan_arbiter_if #(.REQ_NUM(REQ_NUM), .ADDR_W(ADDR_W), .BURST_W(BURST_W)) bus ();

  ddr_chan_arbiter #(.REQ_NUM(REQ_NUM), .ADDR_W(ADDR_W), .BURST_W(BURST_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_desc(input int i, input logic [31:0] a, input logic [15:0] b,
                          input logic [31:0] s, input logic [15:0] n);
    bus.req_st_addr[i*ADDR_W +: ADDR_W]     = a;
    bus.req_burst[i*BURST_W +: BURST_W]     = b;
    bus.req_step[i*ADDR_W +: ADDR_W]        = s;
    bus.req_burst_num[i*BURST_W +: BURST_W] = n;
  endtask

  // Entered in an ISSUE cycle; leaves two cycles after this grant's done.
  task automatic serve(input int own, input bit rereq, input bit next);
    chk("fair_start", bus.wr_start, 1);
    chk("fair_owner", bus.owner, own);
    chk("fair_addr", bus.wr_st_addr, (own == 1) ? 32'h4000 : 32'h3000);
    tick();
    bus.wr_done = 1'b1;
    tick();
    bus.wr_done = 1'b0;
    chk("fair_done", bus.req_done, (own == 1) ? 2'b10 : 2'b01);
    if (rereq) bus.req_start[own] = 1'b1;
    tick();
    bus.req_start = '0;
    chk("fair_next", bus.wr_start, next);
  endtask

  initial begin
    bus.req_start     = '0;
    bus.req_st_addr   = '0;
    bus.req_burst     = '0;
    bus.req_step      = '0;
    bus.req_burst_num = '0;
    bus.wr_done       = 1'b0;
    bus.err_clr       = 1'b0;

    tick();
    tick();
    chk("rst_wr_start", bus.wr_start, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_req_done", bus.req_done, 0);
    chk("rst_err_ovf", bus.err_ovf, 0);
    chk("rst_owner", bus.owner, 0);
    chk("rst_wr_st_addr", bus.wr_st_addr, 0);
    chk("rst_pend", dut.pend, 0);
    rst = 1'b1;
    tick();

    // single request on slot 0
    set_desc(0, 32'h1000, 16'h40, 32'h200, 16'd3);
    bus.req_start = 2'b01;
    tick();
    bus.req_start = '0;
    chk("single_t1_wr_start", bus.wr_start, 0);
    chk("single_t1_pend", dut.pend, 2'b01);
    tick();
    chk("single_wr_start", bus.wr_start, 1);
    chk("single_addr", bus.wr_st_addr, 32'h1000);
    chk("single_burst", bus.wr_burst, 16'h40);
    chk("single_step", bus.wr_step, 32'h200);
    chk("single_num", bus.wr_burst_num, 16'd3);
    chk("single_busy", bus.busy, 1);
    chk("single_owner", bus.owner, 0);
    tick();
    chk("single_wait_start", bus.wr_start, 0);
    chk("single_wait_busy", bus.busy, 1);
    bus.wr_done = 1'b1;
    tick();
    bus.wr_done = 1'b0;
    chk("single_req_done", bus.req_done, 2'b01);
    chk("single_busy_off", bus.busy, 0);
    tick();
    chk("single_req_done_off", bus.req_done, 0);
    chk("single_addr_hold", bus.wr_st_addr, 32'h1000);

    // simultaneous requests from rr_ptr=0
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    set_desc(0, 32'h3000, 16'h10, 32'h40, 16'd1);
    set_desc(1, 32'h4000, 16'h20, 32'h80, 16'd2);
    bus.req_start = 2'b11;
    tick();
    bus.req_start = '0;
    tick();
    chk("sim_start0", bus.wr_start, 1);
    chk("sim_owner0", bus.owner, 0);
    chk("sim_addr0", bus.wr_st_addr, 32'h3000);
    tick();
    bus.wr_done = 1'b1;
    tick();
    bus.wr_done = 1'b0;
    chk("sim_done0", bus.req_done, 2'b01);
    chk("sim_gap", bus.wr_start, 0);
    tick();
    chk("sim_start1", bus.wr_start, 1);
    chk("sim_owner1", bus.owner, 1);
    chk("sim_addr1", bus.wr_st_addr, 32'h4000);
    chk("sim_burst1", bus.wr_burst, 16'h20);
    tick();
    bus.wr_done = 1'b1;
    tick();
    bus.wr_done = 1'b0;
    chk("sim_done1", bus.req_done, 2'b10);
    tick();
    chk("sim_idle", bus.busy, 0);

    // fairness: grants must alternate while both keep requesting
    bus.req_start = 2'b11;
    tick();
    bus.req_start = '0;
    tick();
    serve(0, 1, 1);
    serve(1, 1, 1);
    serve(0, 1, 1);
    serve(1, 0, 1);
    serve(0, 0, 0);

    // overflow on slot 1 while pending
    set_desc(1, 32'h5000, 16'h30, 32'h100, 16'd4);
    bus.req_start = 2'b10;
    tick();
    set_desc(1, 32'h6000, 16'h31, 32'h101, 16'd5);
    bus.req_start = 2'b10;
    tick();
    bus.req_start = '0;
    chk("ovf_flag", bus.err_ovf, 2'b10);
    chk("ovf_start", bus.wr_start, 1);
    chk("ovf_addr", bus.wr_st_addr, 32'h5000);
    chk("ovf_burst", bus.wr_burst, 16'h30);
    chk("ovf_num", bus.wr_burst_num, 16'd4);
    tick();
    bus.wr_done = 1'b1;
    tick();
    bus.wr_done = 1'b0;
    chk("ovf_done", bus.req_done, 2'b10);
    tick();
    chk("ovf_done_once", bus.req_done, 0);
    chk("ovf_no_reissue", bus.wr_start, 0);
    chk("ovf_idle", bus.busy, 0);
    chk("ovf_sticky", bus.err_ovf, 2'b10);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("ovf_clear", bus.err_ovf, 0);

    // spurious done in IDLE and ISSUE
    bus.wr_done = 1'b1;
    tick();
    bus.wr_done = 1'b0;
    chk("spur_idle_done", bus.req_done, 0);
    chk("spur_idle_busy", bus.busy, 0);
    set_desc(0, 32'h7000, 16'h8, 32'h10, 16'd2);
    bus.req_start = 2'b01;
    tick();
    bus.req_start = '0;
    bus.wr_done = 1'b1;
    tick();
    chk("spur_issue_start", bus.wr_start, 1);
    chk("spur_issue_done", bus.req_done, 0);
    chk("spur_issue_addr", bus.wr_st_addr, 32'h7000);
    tick();
    bus.wr_done = 1'b0;
    chk("spur_wait_busy", bus.busy, 1);
    chk("spur_wait_done", bus.req_done, 0);
    chk("spur_wait_start", bus.wr_start, 0);
    tick();
    chk("spur_still_wait", bus.busy, 1);
    bus.wr_done = 1'b1;
    tick();
    bus.wr_done = 1'b0;
    chk("spur_real_done", bus.req_done, 2'b01);
    chk("spur_real_busy", bus.busy, 0);
    tick();

    // reset while WAIT with a pending slot and an overflow flag set
    set_desc(0, 32'h3000, 16'h10, 32'h40, 16'd1);
    set_desc(1, 32'h4000, 16'h20, 32'h80, 16'd2);
    bus.req_start = 2'b11;
    tick();
    bus.req_start = '0;
    tick();
    chk("rmid_owner", bus.owner, 1);
    bus.req_start = 2'b01;
    tick();
    bus.req_start = '0;
    chk("rmid_err", bus.err_ovf, 2'b01);
    chk("rmid_busy", bus.busy, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rmid_wr_start", bus.wr_start, 0);
    chk("rmid_busy_off", bus.busy, 0);
    chk("rmid_err_off", bus.err_ovf, 0);
    chk("rmid_req_done", bus.req_done, 0);
    chk("rmid_pend", dut.pend, 0);
    chk("rmid_rr_ptr", dut.rr_ptr, 0);
    tick();
    rst = 1'b1;
    set_desc(1, 32'h8000, 16'h44, 32'h400, 16'd6);
    bus.req_start = 2'b10;
    tick();
    bus.req_start = '0;
    tick();
    chk("rpost_start", bus.wr_start, 1);
    chk("rpost_owner", bus.owner, 1);
    chk("rpost_addr", bus.wr_st_addr, 32'h8000);
    tick();
    bus.wr_done = 1'b1;
    tick();
    bus.wr_done = 1'b0;
    chk("rpost_done", bus.req_done, 2'b10);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ddr_chan_arbiter.md
Name: ddr_chan_arbiter

Overview:
- Shares one DDR transfer engine between REQ_NUM channel configurators, such as the ddr1/ddr2 start/config outputs of the PE-to-DDR config unit.
- Latches each requester's one-cycle start pulse and its burst descriptor, then grants the engine round-robin.
- Issues the selected descriptor with a one-cycle wr_start and routes the engine's done pulse back to the owning requester.

Parameters:
REQ_NUM, 2, number of requesters (2..4)
ADDR_W, 32, DDR address / step width (DDR_ADDR_W)
BURST_W, 16, burst length / burst count width (BURST_W)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
req_start  in  REQ_NUM  per-requester one-cycle start pulse
req_st_addr  in  REQ_NUM*ADDR_W  start address, slot i at [i*ADDR_W +: ADDR_W]
req_burst  in  REQ_NUM*BURST_W  burst length per slot
req_step  in  REQ_NUM*ADDR_W  address step per burst per slot
req_burst_num  in  REQ_NUM*BURST_W  burst count per slot
req_done  out  REQ_NUM  one-cycle completion pulse to the owner
wr_start  out  1  one-cycle start to the DDR engine
wr_st_addr  out  ADDR_W  issued descriptor
wr_burst  out  BURST_W  issued descriptor
wr_step  out  ADDR_W  issued descriptor
wr_burst_num  out  BURST_W  issued descriptor
wr_done  in  1  engine completion pulse
busy  out  1  engine owned (state != IDLE)
owner  out  bw(REQ_NUM)  index of current/last granted slot
err_ovf  out  REQ_NUM  sticky overflow flags
err_clr  in  1  clears err_ovf

Behaviour:
- Reset (rst=0, async): all outputs 0, pend=0, rr_ptr=0, state=IDLE. Reset mid-transfer drops wr_start immediately and abandons the transfer; no req_done is produced.
- Slot i is busy when pend[i]=1, or when state!=IDLE and owner==i.
- req_start[i] while slot i is not busy:
  - capture slot i descriptor into holding registers;
  - pend[i]<=1.
- req_start[i] while slot i is busy:
  - pulse is dropped, descriptor is not captured;
  - err_ovf[i]<=1, sticky.
- err_clr clears err_ovf. A simultaneous overflow has priority and sets the flag.
- FSM IDLE:
  - if any pend, select the first set pend at or after rr_ptr, wrapping modulo REQ_NUM;
  - load wr_* from that slot's holding registers, owner<=sel, pend[sel]<=0, go to ISSUE.
- FSM ISSUE: wr_start=1 for exactly this cycle, then go to WAIT.
- FSM WAIT:
  - on wr_done: req_done[owner] pulses in the next cycle (registered);
  - rr_ptr<=(owner+1) mod REQ_NUM;
  - go to IDLE.
- wr_done while in IDLE or ISSUE is ignored.
- wr_* descriptor outputs hold their value from grant until the next grant.
- Latency:
  - req_start at cycle t: pend visible t+1, wr_start high at t+2 if the engine is idle;
  - wr_done at cycle d: req_done at d+1, next wr_start at the earliest d+2.
- Arithmetic: rr_ptr and owner wrap modulo REQ_NUM. For non-power-of-2 REQ_NUM, values >= REQ_NUM never occur.
- One outstanding descriptor per slot. A new req_start for slot i is accepted from the cycle the req_done[i] pulse is high.

Test Plan:
- Single request: req_start[0] at t with st_addr=0x1000, burst=0x40, step=0x200, burst_num=3 -> wr_start at t+2 carrying the same values, busy=1; wr_done at d -> req_done[0] at d+1, busy=0 at d+1.
- Simultaneous requests: req_start=2'b11 at t with rr_ptr=0 -> slot 0 issued at t+2; after its wr_done, slot 1 issued 2 cycles later; owner 0 then 1.
- Fairness: slot 0 re-requests on every req_done[0] while slot 1 stays pending -> grants alternate 0,1,0,1; no slot is granted twice in a row while the other is pending.
- Overflow: second req_start[1] while pend[1]=1 -> err_ovf[1]=1, original descriptor is issued unchanged, only one req_done[1]; err_clr -> err_ovf=0.
- Spurious done: wr_done pulsed in IDLE and in the ISSUE cycle -> no req_done, state unchanged; the real wr_done in WAIT completes normally.
- Reset mid-op: rst=0 during WAIT -> wr_start, busy, pend, err_ovf, req_done all 0 asynchronously; after release, a new req_start[1] issues at +2 with rr_ptr=0.
